// File: rtl/park_pkg.sv
// park_pkg: shared state type and default sizing for the parking gate controller.
package park_pkg;
  typedef enum logic [2:0] {IDLE, READY, GATE_IN, GATE_OUT, CLOSED} park_state_t;
  localparam int PARK_CAPACITY = 3;
  localparam int PARK_HOURS = 8;
  localparam int PARK_GATE_CYCLES = 4;
  localparam int HOUR_W = 3;
endpackage

// File: rtl/park_arbiter.sv
// park_arbiter: one-hot entry/exit grant; round-robin when PARK_RR_ARB_EN is defined, else exit priority.
module park_arbiter (
`ifdef PARK_RR_ARB_EN
  input  logic clk,
  input  logic reset,
  input  logic take,
`endif
  input  logic req_in,
  input  logic req_out,
  output logic gnt_in,
  output logic gnt_out
);
`ifdef PARK_RR_ARB_EN
  logic last_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_in <= 1'b0;
    else if (take) last_in <= gnt_in;
  assign gnt_in = req_in && (!req_out || !last_in);
`else
  assign gnt_in = req_in && !req_out;
`endif
  assign gnt_out = req_out && !gnt_in;
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: sequences gate grants, gate-open timing and the business-day hour count.
// Optional round-robin contention arbitration is enabled by defining PARK_RR_ARB_EN.
module parking_gate_ctrl import park_pkg::*; #(
  parameter int CAPACITY = PARK_CAPACITY,
  parameter int GATE_CYCLES = PARK_GATE_CYCLES,
  parameter int HOURS = PARK_HOURS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hour_tick,
  input  logic              car_in_req,
  input  logic              car_out_req,
  input  logic [1:0]        num,
  output logic              enter,
  output logic              exit,
  output logic              gate_in_open,
  output logic              gate_out_open,
  output logic [HOUR_W-1:0] hours,
  output logic              full,
  output logic              day_over,
  output logic              busy
);
  localparam int CW = $clog2(GATE_CYCLES + 1);
  park_state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [HOUR_W-1:0] hours_d;
  logic day_over_d, gnt_in, gnt_out, ready, tick, last_hour;
  assign full = num == 2'(CAPACITY);
  assign ready = state == READY;
  assign tick = hour_tick && (ready || state == GATE_IN || state == GATE_OUT);
  assign last_hour = hours == HOUR_W'(HOURS - 1);
  park_arbiter u_arb (
`ifdef PARK_RR_ARB_EN
    .clk(clk),
    .reset(reset),
    .take(gnt_in || gnt_out),
`endif
    .req_in(ready && car_in_req && num < 2'(CAPACITY)),
    .req_out(ready && car_out_req && num != 2'd0),
    .gnt_in(gnt_in),
    .gnt_out(gnt_out)
  );
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    hours_d = tick && !last_hour ? hours + 1'b1 : hours;
    day_over_d = day_over || (tick && last_hour);
    case (state)
      IDLE: if (start) begin
        state_d = READY;
        hours_d = '0;
      end
      READY: if (gnt_in || gnt_out) begin
        state_d = gnt_in ? GATE_IN : GATE_OUT;
        cnt_d = CW'(GATE_CYCLES - 1);
      end else if (day_over_d) state_d = CLOSED;
      GATE_IN, GATE_OUT: if (cnt == '0) state_d = day_over_d ? CLOSED : READY;
      else cnt_d = cnt - 1'b1;
      CLOSED: if (start) begin
        state_d = READY;
        hours_d = '0;
        day_over_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Gate outputs are registered copies of the next state, so they rise with the grant edge.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      hours <= '0;
      day_over <= 1'b0;
      enter <= 1'b0;
      exit <= 1'b0;
      gate_in_open <= 1'b0;
      gate_out_open <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      hours <= hours_d;
      day_over <= day_over_d;
      enter <= gnt_in;
      exit <= gnt_out;
      gate_in_open <= state_d == GATE_IN;
      gate_out_open <= state_d == GATE_OUT;
      busy <= state_d == GATE_IN || state_d == GATE_OUT;
    end
endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Controller that sequences the parking-lot occupancy datapath. It arbitrates between the entrance and exit gate sensors and refuses entry when the lot is full. It drives one-cycle `enter`/`exit` pulses into the datapath, holds the gate-open outputs for a fixed interval, and keeps the 3-bit hour count for the business day. It sits between the board I/O (sensors, hour tick, start key) and the occupancy/rush-hour datapath.

## Interface
Parameters:
- `CAPACITY`, default 3: lot size; entry is refused when `num == CAPACITY`.
- `GATE_CYCLES`, default 4: cycles each gate stays open per car (legal range ≥ 2).
- `HOURS`, default 8: hours per day (legal range ≤ 8).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle pulse; opens the day.
- `hour_tick`  in  1  one-cycle pulse marking the end of the current hour.
- `car_in_req`  in  1  level; a car is waiting at the entrance.
- `car_out_req`  in  1  level; a car is waiting at the exit.
- `num`  in  2  current occupancy from the datapath.
- `enter`  out  1  one-cycle pulse to the datapath.
- `exit`  out  1  one-cycle pulse to the datapath.
- `gate_in_open`  out  1  entrance gate open.
- `gate_out_open`  out  1  exit gate open.
- `hours`  out  3  current hour, 0 to HOURS-1; drives the datapath `hours` input.
- `full`  out  1  combinational; equals `num == CAPACITY`.
- `day_over`  out  1  the final hour has ended.
- `busy`  out  1  a gate sequence is in progress.

## Operation
- FSM states: IDLE, READY, GATE_IN, GATE_OUT, CLOSED.
- IDLE: a `start` pulse moves the FSM to READY and clears `hours`.
- READY, entry grant: requires `car_in_req && num < CAPACITY`.
- READY, exit grant: requires `car_out_req && num > 0`.
- READY, contention: when both requests are grantable, the arbiter picks one (see Configuration).
- An entry grant moves the FSM to GATE_IN; an exit grant moves it to GATE_OUT.
- GATE_x:
  - The matching gate output is high for exactly GATE_CYCLES cycles.
  - `enter`/`exit` is high in the first GATE cycle only.
  - Requests are ignored.
  - Afterwards the FSM returns to READY, or to CLOSED if `day_over` is set.
- Every service is followed by at least one READY cycle, so the updated `num` is seen before the next grant.
- `hour_tick` in READY or GATE_x:
  - If `hours < HOURS-1`: `hours` increments.
  - Otherwise: `hours` holds and `day_over` sets.
  - From READY, `day_over` setting moves the FSM to CLOSED; a gate sequence already in progress completes first.
- CLOSED: no grants, `hours` holds. A `start` pulse clears `hours` and `day_over` and moves the FSM to READY.
- `start` is ignored in READY and GATE_x. `hour_tick` is ignored in IDLE and CLOSED.
- Same-cycle `hour_tick` and grant: both take effect.

## Timing
- Reset values: state IDLE. `enter`, `exit`, `gate_in_open`, `gate_out_open`, `busy`, `day_over` all 0. `hours` = 0. Arbiter pointer = "exit last".
- All outputs except `full` are registered.
- Request grantable in READY at edge k: `enter`/`exit` and the gate output go high after edge k.
- The gate output falls after edge k+GATE_CYCLES.
- The earliest next grant is sampled at edge k+GATE_CYCLES+1.
- Gate counter width is $clog2(GATE_CYCLES+1); it is loaded at grant and counts down.
- Reset asserted mid-gate: all outputs clear immediately (asynchronously); no partial pulse is re-issued after release.

## Configuration
- `PARK_RR_ARB_EN`:
  - Defined: round-robin on contention; the side not served last wins. The pointer updates on every grant.
  - Undefined: fixed priority, exit wins, which frees a space; no pointer register is built.
- Non-contention grants behave identically in both builds.

## Structure
- `park_pkg` holds:
  - the state enum `park_state_t`;
  - default constants `PARK_CAPACITY`, `PARK_HOURS`, `PARK_GATE_CYCLES`;
  - `HOUR_W` = 3.
- Sub-module `park_arbiter`: combinational grant logic plus the optional round-robin pointer flop. Inputs: two qualified requests and a grant-taken strobe. Outputs: one-hot grant.

## Test plan
- Start, `car_in_req` held with `num` fed back 0→1→2→3: three `enter` pulses spaced GATE_CYCLES+1 apart, then `full`=1 and no further grant.
- `num`=3, both requests held: default build gives exit. With `PARK_RR_ARB_EN`, alternating exit/entry grants once `num`=2.
- 8 `hour_tick` pulses: `hours` goes 0..7, `day_over`=1 on the 8th pulse, and the FSM reaches CLOSED. A subsequent `start` gives `hours`=0, `day_over`=0.
- `hour_tick` as the 8th pulse during GATE_IN cycle 2: the gate finishes its 4 cycles, then CLOSED; no new grant despite `car_out_req`.
- Reset low during GATE_OUT cycle 2: `gate_out_open`=0 and `busy`=0 at once; after release, state IDLE and `hours`=0.
